// File: rtl/rom_seq_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_seq_reader_pkg
// Description : Shared definitions for the ROM sequential reader: default
//               ROM geometry and read latency, plus the reader FSM state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_seq_reader_pkg;

    localparam int c_ADDR_W   = 4;
    localparam int c_DATA_W   = 4;
    localparam int c_READ_LAT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : rom_seq_reader_pkg
`default_nettype wire

// File: rtl/rom_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rom_seq_fifo
// Description : Small synchronous FIFO holding returned ROM words until the
//               consumer accepts them. Push and pop may coincide. The head is
//               forced to zero while empty so the output is clean at reset.
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               push, push_data - write one word
//               pop             - remove the head word (only when not empty)
//               head, empty     - oldest word and empty flag
//               count           - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module rom_seq_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = empty ? '0 : r_mem[r_rptr];

endmodule : rom_seq_fifo
`default_nettype wire

// File: rtl/rom_seq_reader.sv
`default_nettype none
// ============================================================================
// Module      : rom_seq_reader
// Description : Streams a range of words out of a synchronous ROM with a
//               valid/ready output. Bursts run start_addr..end_addr inclusive
//               with modulo-2^ADDR_W wrap, optionally looping until stop.
//               Optional feature macro: ROM_SEQ_READER_CHECKSUM_EN adds an
//               8-bit wrapping sum of transferred words on port checksum.
// Ports       : inclk, rst_n          - clock, synchronous active-low reset
//               start, loop, stop      - burst control
//               start_addr, end_addr   - burst range (inclusive)
//               rom_addr, rom_q        - ROM address out / read data in
//               data_out, data_valid,
//               data_ready             - output handshake
//               busy, done             - burst active / one-cycle completion
//               checksum (optional)    - sum of transferred words
// Revision    : 1.0 - initial release
// ============================================================================
module rom_seq_reader
    import rom_seq_reader_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W,
    parameter int DATA_W   = c_DATA_W,
    parameter int READ_LAT = c_READ_LAT
) (
    input  logic              inclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              loop,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              done
`ifdef ROM_SEQ_READER_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    localparam int c_DEPTH = READ_LAT + 1;
    localparam int c_CNT_W = $clog2(c_DEPTH + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_start;
    logic [ADDR_W-1:0]  r_end;
    logic [ADDR_W-1:0]  r_cur;
    logic [ADDR_W-1:0]  r_last;
    logic               r_loop;
    logic [READ_LAT-1:0] r_pipe;

    logic               w_accept_start;
    logic               w_issue;
    logic               w_pop;
    logic               w_push;
    logic               w_credit;
    int                 w_inflight;
    logic [c_CNT_W-1:0] w_fifo_count;
    logic               w_fifo_empty;
    logic [DATA_W-1:0]  w_head;

    // ------------------------------------------------------------------
    // Credit: reads the ROM has sampled but not yet returned, plus words
    // already buffered, may never exceed the FIFO depth. A word leaving
    // the FIFO this cycle frees its slot immediately, which is what keeps
    // the stream at one word per cycle with data_ready held high.
    // ------------------------------------------------------------------
    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < READ_LAT; i++) begin
            w_inflight = w_inflight + (r_pipe[i] ? 1 : 0);
        end
    end

    assign w_pop          = !w_fifo_empty && data_ready;
    assign w_push         = r_pipe[READ_LAT-1];
    assign w_credit       = (w_inflight + int'(w_fifo_count) - (w_pop ? 1 : 0)) < c_DEPTH;
    assign w_accept_start = (r_state == IDLE) && start;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge inclk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (stop) begin
                    w_state_nxt = DRAIN;
                end else if (w_credit) begin
                    w_issue = 1'b1;
                    if ((r_cur == r_end) && !r_loop) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((w_inflight == 0) && w_fifo_empty) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address generation. The ROM samples rom_addr on the edge that
    // completes the issue cycle, so the address is presented in the same
    // cycle the issue decision is made and held otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge inclk) begin
        if (!rst_n) begin
            r_start <= '0;
            r_end   <= '0;
            r_cur   <= '0;
            r_last  <= '0;
            r_loop  <= 1'b0;
        end else begin
            if (w_accept_start) begin
                r_start <= start_addr;
                r_end   <= end_addr;
                r_loop  <= loop;
                r_cur   <= start_addr;
            end else if (w_issue) begin
                r_last <= r_cur;
                r_cur  <= (r_cur == r_end) ? r_start : r_cur + ADDR_W'(1);
            end
        end
    end

    assign rom_addr = w_issue ? r_cur : r_last;

    // ------------------------------------------------------------------
    // Read-latency tracker: bit i set means a read sampled i+1 edges ago.
    // The top bit marks rom_q as holding that read's word this cycle.
    // ------------------------------------------------------------------
    if (READ_LAT == 1) begin : g_pipe_lat1
        always_ff @(posedge inclk) begin
            if (!rst_n) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= w_issue;
            end
        end
    end else begin : g_pipe_latn
        always_ff @(posedge inclk) begin
            if (!rst_n) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= {r_pipe[READ_LAT-2:0], w_issue};
            end
        end
    end

    rom_seq_fifo #(
        .DEPTH (c_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (inclk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (rom_q),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign data_out   = w_head;
    assign data_valid = !w_fifo_empty;
    assign busy       = (r_state == FETCH) || (r_state == DRAIN);
    assign done       = (r_state == DONE);

`ifdef ROM_SEQ_READER_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge inclk) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_accept_start) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + 8'(w_head);
        end
    end

    assign checksum = r_checksum;
`endif

endmodule : rom_seq_reader
`default_nettype wire

// File: tb/tb_rom_seq_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_seq_reader
// Description : Scoreboard bench for rom_seq_reader with a latency-1 ROM
//               model. Stimulus pushes expected words; a negedge monitor
//               pops and compares on every transfer and checks that a
//               stalled word is held.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_seq_reader;

    localparam logic [3:0] ROM_TBL [16] = '{4'd3, 4'd10, 4'd1, 4'd8, 4'd15, 4'd6, 4'd13, 4'd4,
                                             4'd11, 4'd2, 4'd9, 4'd0, 4'd7, 4'd14, 4'd5, 4'd12};

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       loop;
    logic       stop;
    logic [3:0] start_addr;
    logic [3:0] end_addr;
    logic [3:0] rom_addr;
    logic [3:0] rom_q;
    logic [3:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       busy;
    logic       done;
`ifdef ROM_SEQ_READER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int         checks = 0;
    int         errors = 0;
    int         xfer_cnt = 0;
    logic [3:0] exp_q [$];
    logic [7:0] exp_sum = 8'd0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_data = 4'd0;
    logic       stall_mode = 1'b0;
    int         stall_cyc = 0;

    rom_seq_reader #(
        .ADDR_W   (4),
        .DATA_W   (4),
        .READ_LAT (1)
    ) dut (
        .inclk      (clk),
        .rst_n      (rst_n),
        .start      (start),
        .loop       (loop),
        .stop       (stop),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done)
`ifdef ROM_SEQ_READER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one cycle clock-to-q.
    always @(posedge clk) rom_q <= ROM_TBL[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer stall pattern 1,0,0,1 repeating.
    always @(posedge clk) begin
        #1;
        if (stall_mode) begin
            data_ready = ((stall_cyc % 4) == 0) || ((stall_cyc % 4) == 3);
            stall_cyc++;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold valid", data_valid, 1);
                check("hold data", data_out, prev_data);
            end
            if (data_valid && data_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra word: got %0d with no word expected", data_out);
                end else begin
                    check("word", data_out, exp_q.pop_front());
                end
            end
            prev_stall = data_valid && !data_ready;
            prev_data  = data_out;
        end
    end

    task automatic push_range(input logic [3:0] s, input logic [3:0] e);
        logic [3:0] a;
        a = s;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(ROM_TBL[a]);
            exp_sum = exp_sum + {4'd0, ROM_TBL[a]};
            if (a == e) break;
            a = a + 4'd1;
        end
    endtask

    // Start a burst and check the first-word latency of READ_LAT+1 cycles.
    task automatic do_burst(input string tag, input logic [3:0] s, input logic [3:0] e, input logic lp);
        start_addr = s;
        end_addr   = e;
        loop       = lp;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        start_addr = ~s;
        end_addr   = ~e;
        loop       = 1'b0;
        check({tag, " busy after start"}, busy, 1);
        check({tag, " valid cyc1"}, data_valid, 0);
        tick();
        check({tag, " valid cyc1b"}, data_valid, 0);
        tick();
        check({tag, " first valid cyc2"}, data_valid, 1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check({tag, " done"}, done, 1);
        check({tag, " busy at done"}, busy, 0);
        check({tag, " words left"}, exp_q.size(), 0);
`ifdef ROM_SEQ_READER_CHECKSUM_EN
        check({tag, " checksum"}, checksum, exp_sum);
`endif
        tick();
        check({tag, " done one cycle"}, done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        loop       = 1'b0;
        stop       = 1'b0;
        start_addr = 4'd0;
        end_addr   = 4'd0;
        data_ready = 1'b1;
        tick();
        tick();
        check("reset rom_addr", rom_addr, 0);
        check("reset data_valid", data_valid, 0);
        check("reset data_out", data_out, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
`ifdef ROM_SEQ_READER_CHECKSUM_EN
        check("reset checksum", checksum, 0);
`endif
        rst_n = 1'b1;
        tick();

        // stop in IDLE has no effect
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("idle stop busy", busy, 0);

        // full range, plus a start while busy that must be ignored
        exp_sum = 8'd0;
        push_range(4'd0, 4'd15);
        do_burst("s1", 4'd0, 4'd15, 1'b0);
        start_addr = 4'd9;
        end_addr   = 4'd9;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        wait_done("s1");

        // wrap across address 15 -> 0
        exp_sum = 8'd0;
        push_range(4'd14, 4'd1);
        do_burst("s2", 4'd14, 4'd1, 1'b0);
        wait_done("s2");

        // single word
        exp_sum = 8'd0;
        push_range(4'd5, 4'd5);
        do_burst("s3", 4'd5, 4'd5, 1'b0);
        wait_done("s3");

        // consumer back-pressure
        exp_sum    = 8'd0;
        stall_cyc  = 0;
        stall_mode = 1'b1;
        push_range(4'd0, 4'd7);
        do_burst("s4", 4'd0, 4'd7, 1'b0);
        wait_done("s4");
        stall_mode = 1'b0;
        tick();
        data_ready = 1'b1;

        // loop 2..4, stop after seven transfers; words 3 and 4 are in
        // flight at the stop and drain afterwards.
        exp_sum = 8'd0;
        push_range(4'd2, 4'd4);
        push_range(4'd2, 4'd4);
        push_range(4'd2, 4'd4);
        xfer_cnt = 0;
        do_burst("s5", 4'd2, 4'd4, 1'b1);
        for (int n = 0; n < 100 && xfer_cnt < 7; n++) tick();
        check("s5 transfers before stop", xfer_cnt, 7);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("s5");
        check("s5 rom_addr held", rom_addr, 4);

        // reset in the middle of a burst, then a clean burst
        exp_sum = 8'd0;
        push_range(4'd0, 4'd15);
        do_burst("s6", 4'd0, 4'd15, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst data_valid", data_valid, 0);
        check("midrst data_out", data_out, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst rom_addr", rom_addr, 0);
`ifdef ROM_SEQ_READER_CHECKSUM_EN
        check("midrst checksum", checksum, 0);
`endif
        rst_n = 1'b1;
        exp_q.delete();
        exp_sum = 8'd0;
        tick();
        check("post reset idle done", done, 0);
        push_range(4'd3, 4'd6);
        do_burst("s7", 4'd3, 4'd6, 1'b0);
        wait_done("s7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rom_seq_reader
`default_nettype wire

// File: doc/rom_seq_reader.md
ROM_SEQ_READER -- requirements
Module: rom_seq_reader

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 4, ROM address width; DATA_W, default 4, ROM word width; READ_LAT, default 1, ROM clock-to-q latency in cycles (1..2).
REQ-002 Ports SHALL be, clock and reset first:
- inclk, input, 1, single clock; the ROM shares this clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, one-cycle pulse that begins a burst.
- loop, input, 1, when 1 the burst repeats until stop.
- stop, input, 1, pulse that ends the burst after in-flight words drain.
- start_addr, input, ADDR_W, first address.
- end_addr, input, ADDR_W, last address, inclusive.
- rom_addr, output, ADDR_W, address driven to the ROM.
- rom_q, input, DATA_W, ROM read data.
- data_out, output, DATA_W, emitted word.
- data_valid, output, 1, data_out is valid.
- data_ready, input, 1, consumer accepts the word this cycle.
- busy, output, 1, a burst is active.
- done, output, 1, one-cycle pulse when a burst fully drains.
REQ-003 The block SHALL have one clock domain and a synchronous, active-low reset (rst_n sampled on the inclk rising edge).

Function
REQ-004 The FSM SHALL have the states IDLE, FETCH, DRAIN and DONE.
REQ-005 IDLE->FETCH on start; the block SHALL latch start_addr, end_addr and loop at that edge.
REQ-006 In FETCH, the block SHALL issue one address per cycle from start_addr upward; it issues an address only when (in-flight reads + output buffer occupancy) < READ_LAT+1.
REQ-007 The returned rom_q SHALL be captured READ_LAT cycles after its address into an output FIFO of depth READ_LAT+1, in issue order.
REQ-008 Address increment SHALL wrap modulo 2^ADDR_W. If end_addr < start_addr, the burst crosses the wrap point (e.g. 14,15,0,1). If end_addr == start_addr, the burst is exactly one word.
REQ-009 After issuing end_addr: if loop=1, the next issued address SHALL be start_addr; otherwise the FSM goes to DRAIN.
REQ-010 stop in FETCH SHALL move the FSM to DRAIN with no further addresses issued. stop in IDLE, DRAIN or DONE SHALL be ignored.
REQ-011 DRAIN->DONE when in-flight reads = 0 and the FIFO is empty. DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-012 Output handshake: a word transfers when data_valid && data_ready. data_out and data_valid SHALL stay stable while data_valid && !data_ready. No word may be dropped or duplicated.
REQ-013 start while busy=1 SHALL be ignored.
REQ-014 busy SHALL be 1 in FETCH and DRAIN. rom_addr SHALL hold its last value when no address is issued.
REQ-015 With data_ready held at 1, the first data_valid SHALL occur READ_LAT+1 cycles after the start edge, and throughput SHALL be one word per cycle.

Reset
REQ-016 When rst_n=0, the block SHALL set: FSM to IDLE, rom_addr=0, data_out=0, data_valid=0, busy=0, done=0, FIFO empty, in-flight count 0.
REQ-017 Reset mid-burst SHALL discard all in-flight and buffered words. No done pulse is produced.

Configuration
REQ-018 With macro ROM_SEQ_READER_CHECKSUM_EN defined, the block SHALL add output checksum[7:0]:
- checksum is the 8-bit wrapping sum of all transferred words.
- It is cleared on accepted start and on reset.
- It is valid when done=1.
Without the macro, the port and its logic SHALL be absent.

Structure
REQ-019 A shared package SHALL hold the FSM state enum and the default ADDR_W/DATA_W constants.
REQ-020 The output FIFO SHALL be a sub-module named rom_seq_fifo, parameterised by depth and width.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- start_addr=0, end_addr=15, loop=0, data_ready=1 -> 16 words equal to ROM[0..15] in order; first valid at cycle 2 after start; done once; busy falls with done.
- start_addr=14, end_addr=1 -> words ROM[14], ROM[15], ROM[0], ROM[1], then done.
- start_addr=end_addr=5 -> exactly one word, ROM[5], then done.
- addresses 0..7 with data_ready toggling 1,0,0,1,... -> all 8 words delivered in order; data_out held stable while stalled; no overflow.
- loop=1 over 2..4, stop after 7 transfers -> sequence 2,3,4,2,3,4,2, then the in-flight words drain, then done; nothing is issued after stop.
- rst_n=0 asserted mid-burst -> next cycle all outputs are 0 and the block is in IDLE; a new start works normally; with ROM_SEQ_READER_CHECKSUM_EN defined, checksum equals the modulo-256 sum of the words delivered.
